uart_program_loader: RTL and testbench
======================================

Name: uart_program_loader

Overview:
- Upstream feeder of the single-cycle CPU top. Consumes raw bytes from the UART receiver and assembles little-endian 32-bit words.
- Drives the memory back-door with UartAddress, UartData and a write strobe.
- Raises UartOver once the image is fully written, which releases the CPU from reset.
- Frame format: 4-byte little-endian word count N, then N words of 4 bytes each, least significant byte first.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word.
- MAX_WORDS, 16384, largest accepted N; any larger N is a frame error.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- RxByte  in  8  received byte; valid only while RxValid is high.
- RxValid  in  1  one-cycle strobe per received byte.
- UartData  out  32  assembled word for memory port B.
- UartAddress  out  32  byte address for UartData.
- UartWriteEn  out  1  one-cycle write strobe.
- UartOver  out  1  load complete; sticky until reset.
- LoadError  out  1  frame error; sticky until reset.
- WordCount  out  16  number of words written so far.

Behaviour:
- Reset (asynchronous, active-high) forces the following:
  - state = HEADER;
  - byte index = 0;
  - UartData = 0, UartAddress = BASE_ADDR;
  - UartWriteEn = 0, UartOver = 0, LoadError = 0, WordCount = 0.
- Reset asserted mid-load abandons the frame. The next byte after reset is header byte 0.
- States: HEADER, DATA, DONE, ERROR (plus CHECK when the optional feature is compiled in).
- A byte is accepted in HEADER, DATA and CHECK only when RxValid = 1. Bytes arriving in DONE or ERROR are ignored.
- Byte index (2 bits) selects the shift-in lane, LSB first. It wraps 3 -> 0 on each completed word or header.
- HEADER:
  - On the 4th byte, latch N.
  - If N = 0, go to DONE.
  - If N > MAX_WORDS, go to ERROR.
  - Otherwise go to DATA.
- DATA, on the 4th byte of a word:
  - register the word into UartData;
  - set UartAddress = BASE_ADDR + 4*WordCount (32-bit modular arithmetic);
  - pulse UartWriteEn for exactly one cycle, in the cycle after the accepting RxValid;
  - increment WordCount in that same cycle.
- UartData and UartAddress hold their values between strobes.
- Back-to-back RxValid on consecutive cycles must be accepted without loss. Byte capture runs concurrently with the registered write strobe.
- After word N: go to DONE (or CHECK). UartOver rises in the cycle after the final UartWriteEn pulse, never together with it.
- DONE: UartOver = 1; no further writes.
- ERROR: LoadError = 1, UartOver = 0; no further writes. Only reset leaves ERROR.
- WordCount saturates at 16'hFFFF. Unreachable with the default MAX_WORDS, but required.
- The running XOR of every accepted byte (header and data) is always maintained; it resets to 0.

Optional Feature:
- Macro: UART_LOADER_CHECKSUM_EN.
- Defined:
  - after word N, or directly after the header when N = 0, enter CHECK and wait for one checksum byte;
  - if it equals the running XOR of all preceding frame bytes, go to DONE;
  - otherwise go to ERROR.
  - UartOver rises the cycle after the checksum byte.
- Undefined:
  - CHECK does not exist and no checksum byte is expected;
  - a byte sent after the frame is ignored in DONE.

Test Plan:
- Header 01 00 00 00, then word bytes 13 05 00 00 -> one UartWriteEn pulse with UartData = 32'h0000_0513 and UartAddress = BASE_ADDR; UartOver = 1 on the next cycle; WordCount = 1.
- N = 3, with all 16 bytes on consecutive cycles (RxValid held high) -> three pulses at addresses 0x0, 0x4, 0x8 with correct data; no byte is lost.
- Header 00 00 00 00 -> UartOver = 1 one cycle after the 4th byte; no write pulse occurs.
- N = MAX_WORDS + 1 -> LoadError = 1, UartOver stays 0, no writes; following bytes are ignored.
- Reset pulsed after 2 data bytes of word 0, then a full N = 1 frame -> a single write of the new word at BASE_ADDR; no stale bytes.
- With UART_LOADER_CHECKSUM_EN: N = 1, word AA BB CC DD. Checksum byte 0x01^0xAA^0xBB^0xCC^0xDD = 0x01 -> DONE. Checksum byte 0x00 -> ERROR with LoadError = 1.

Source files
------------

// File: rtl/uart_program_loader.sv
// uart_program_loader
//
// Assembles a program image received over UART and writes it into memory through
// the back-door port. The frame is a 4-byte little-endian word count N, then N
// little-endian 32-bit words. When the whole image has been written, UartOver is
// raised and stays high, which releases the CPU from reset. A malformed frame
// (N > MAX_WORDS, or a bad checksum) raises the sticky LoadError instead.
//
// Optional feature: define UART_LOADER_CHECKSUM_EN to expect one trailing checksum
// byte. It must equal the XOR of every preceding frame byte (header and data).
//
// Parameters:
//   BASE_ADDR    byte address of the first loaded word
//   MAX_WORDS    largest accepted word count N
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   RxByte       received byte, qualified by RxValid
//   RxValid      one-cycle strobe per received byte
//   UartData     assembled word for memory port B
//   UartAddress  byte address of UartData
//   UartWriteEn  one-cycle write strobe
//   UartOver     load complete (sticky until reset)
//   LoadError    frame error (sticky until reset)
//   WordCount    words written so far, saturating at 16'hFFFF

module uart_program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  RxByte,
  input  logic        RxValid,
  output logic [31:0] UartData,
  output logic [31:0] UartAddress,
  output logic        UartWriteEn,
  output logic        UartOver,
  output logic        LoadError,
  output logic [15:0] WordCount
);

  localparam logic [2:0] StHeader = 3'd0;
  localparam logic [2:0] StData   = 3'd1;
  localparam logic [2:0] StDone   = 3'd2;
  localparam logic [2:0] StError  = 3'd3;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam logic [2:0] StCheck  = 3'd4;
  // The image is only complete once the checksum byte has been verified.
  localparam logic [2:0] StFinish = StCheck;
`else
  localparam logic [2:0] StFinish = StDone;
`endif

  logic [2:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] shift_q, shift_d;   // lower three bytes of the word being assembled
  logic [31:0] n_q, n_d;
  logic [31:0] words_q, words_d;   // full-width count drives termination and address
  logic [31:0] data_q, data_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic        over_q, over_d;
  logic        err_q, err_d;
  logic [7:0]  xor_q, xor_d;

  logic        accept;
  logic        last_byte;
  logic [31:0] full_word;
  logic [31:0] words_inc;

  always_comb begin
    accept = 1'b0;
    if (RxValid) begin
      case (state_q)
        StHeader, StData: accept = 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
        StCheck:          accept = 1'b1;
`endif
        default:          accept = 1'b0;
      endcase
    end
  end

  assign last_byte = (idx_q == 2'd3);
  assign full_word = {RxByte, shift_q};
  assign words_inc = words_q + 32'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    n_d     = n_q;
    words_d = words_q;
    data_d  = data_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    xor_d   = xor_q;

    if (accept) begin
      xor_d = xor_q ^ RxByte;
      // Two-bit index wraps 3 -> 0 on its own at the end of every word.
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0:    shift_d[7:0]   = RxByte;
        2'd1:    shift_d[15:8]  = RxByte;
        2'd2:    shift_d[23:16] = RxByte;
        default: shift_d        = shift_q;
      endcase
    end

    case (state_q)
      StHeader: begin
        if (accept && last_byte) begin
          n_d = full_word;
          if (full_word == 32'd0) begin
            state_d = StFinish;
          end else if (full_word > 32'(MAX_WORDS)) begin
            state_d = StError;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept && last_byte) begin
          data_d  = full_word;
          addr_d  = BASE_ADDR + (words_q << 2);
          we_d    = 1'b1;
          words_d = words_inc;
          if (words_inc == n_q) begin
            state_d = StFinish;
          end
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      StCheck: begin
        if (accept) begin
          idx_d   = 2'd0;
          // xor_q holds every frame byte before the checksum byte itself.
          state_d = (RxByte == xor_q) ? StDone : StError;
        end
      end
`endif
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // UartOver is held back while the final write strobe is in flight, so it rises
  // the cycle after that strobe; with no final write it rises on entry to StDone.
  assign over_d = over_q | ((state_d == StDone) && !we_d);
  assign err_d  = err_q | (state_d == StError);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StHeader;
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
      n_q     <= 32'd0;
      words_q <= 32'd0;
      data_q  <= 32'd0;
      addr_q  <= BASE_ADDR;
      we_q    <= 1'b0;
      over_q  <= 1'b0;
      err_q   <= 1'b0;
      xor_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      n_q     <= n_d;
      words_q <= words_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      over_q  <= over_d;
      err_q   <= err_d;
      xor_q   <= xor_d;
    end
  end

  assign UartData    = data_q;
  assign UartAddress = addr_q;
  assign UartWriteEn = we_q;
  assign UartOver    = over_q;
  assign LoadError   = err_q;
  assign WordCount   = (words_q > 32'h0000_FFFF) ? 16'hFFFF : words_q[15:0];

endmodule

// File: tb/tb_uart_program_loader.sv
// Testbench for uart_program_loader: directed frames plus randomized frames with
// random inter-byte gaps, checked against a byte-level frame model.

module tb_uart_program_loader;

  localparam logic [31:0] Base = 32'h0000_0100;
  localparam int unsigned MaxW = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  RxByte = 8'h00;
  logic        RxValid = 1'b0;
  logic [31:0] UartData, UartAddress;
  logic        UartWriteEn, UartOver, LoadError;
  logic [15:0] WordCount;

  int total = 0;
  int bad = 0;

  logic [31:0] words[$];
  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];

  always #5 clk = ~clk;

  uart_program_loader #(
    .BASE_ADDR (Base),
    .MAX_WORDS (MaxW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .RxByte      (RxByte),
    .RxValid     (RxValid),
    .UartData    (UartData),
    .UartAddress (UartAddress),
    .UartWriteEn (UartWriteEn),
    .UartOver    (UartOver),
    .LoadError   (LoadError),
    .WordCount   (WordCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor; also the strobe and completion flag must never coincide.
  always @(negedge clk) begin
    if (!reset) begin
      if (UartWriteEn) begin
        cap_addr.push_back(UartAddress);
        cap_data.push_back(UartData);
      end
      if (UartWriteEn) check("over_with_we", {31'd0, UartOver}, 32'd0);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    RxByte  = b;
    RxValid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      RxValid = 1'b0;
      RxByte  = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    RxValid = 1'b0;
    reset   = 1'b1;
    #1;
    check("rst_data", UartData, 32'd0);
    check("rst_addr", UartAddress, Base);
    check("rst_we", {31'd0, UartWriteEn}, 32'd0);
    check("rst_over", {31'd0, UartOver}, 32'd0);
    check("rst_err", {31'd0, LoadError}, 32'd0);
    check("rst_wc", {16'd0, WordCount}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cap_addr.delete();
    cap_data.delete();
  endtask

  // Sends header + words (+ checksum) and checks strobe/done timing and the writes.
  task automatic load(input bit gaps, input bit bad_ck);
    logic [31:0] n;
    logic [31:0] w;
    logic [7:0]  x;
    n = 32'(words.size());
    x = 8'd0;
    for (int i = 0; i < 4; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      send(n[8*i +: 8]);
      x ^= n[8*i +: 8];
    end
    for (int k = 0; k < int'(n); k++) begin
      w = words[k];
      for (int i = 0; i < 4; i++) begin
        if (gaps) idle($urandom_range(0, 2));
        send(w[8*i +: 8]);
        x ^= w[8*i +: 8];
      end
    end
`ifdef UART_LOADER_CHECKSUM_EN
    if (gaps) idle($urandom_range(0, 2));
    send(bad_ck ? (x ^ 8'h5A) : x);
    idle(1);
    check("ck_we", {31'd0, UartWriteEn}, 32'd0);
    check("ck_over", {31'd0, UartOver}, {31'd0, !bad_ck});
    check("ck_err", {31'd0, LoadError}, {31'd0, bad_ck});
`else
    idle(1);
    if (n == 0) begin
      check("n0_we", {31'd0, UartWriteEn}, 32'd0);
      check("n0_over", {31'd0, UartOver}, 32'd1);
    end else begin
      check("last_we", {31'd0, UartWriteEn}, 32'd1);
      check("last_over", {31'd0, UartOver}, 32'd0);
      idle(1);
      check("post_we", {31'd0, UartWriteEn}, 32'd0);
      check("post_over", {31'd0, UartOver}, 32'd1);
    end
    check("load_err", {31'd0, LoadError}, {31'd0, bad_ck});
`endif
    idle(2);
    check("n_writes", 32'(cap_addr.size()), n);
    for (int k = 0; k < int'(n) && k < cap_addr.size(); k++) begin
      check("wr_addr", cap_addr[k], Base + 32'(4 * k));
      check("wr_data", cap_data[k], words[k]);
    end
    check("wcount", {16'd0, WordCount}, n);
  endtask

  initial begin
    logic [31:0] hdr;

    do_reset();

    // Single word 0x00000513.
    words = '{32'h0000_0513};
    load(1'b0, 1'b0);

    // Bytes after completion are ignored.
    for (int i = 0; i < 4; i++) send(8'($urandom));
    idle(3);
    check("ign_writes", 32'(cap_addr.size()), 32'd1);
    check("ign_wc", {16'd0, WordCount}, 32'd1);
    check("ign_over", {31'd0, UartOver}, 32'd1);

    // Three words, back-to-back bytes.
    do_reset();
    words = '{32'h1111_0001, 32'hDEAD_BEEF, 32'h8000_0003};
    load(1'b0, 1'b0);

    // Empty image.
    do_reset();
    words.delete();
    load(1'b0, 1'b0);

    // Oversized header is a frame error; further bytes are ignored.
    do_reset();
    hdr = 32'(MaxW + 1);
    for (int i = 0; i < 4; i++) send(hdr[8*i +: 8]);
    idle(2);
    check("big_err", {31'd0, LoadError}, 32'd1);
    check("big_over", {31'd0, UartOver}, 32'd0);
    for (int i = 0; i < 8; i++) send(8'($urandom));
    idle(3);
    check("big_writes", 32'(cap_addr.size()), 32'd0);
    check("big_err2", {31'd0, LoadError}, 32'd1);
    check("big_over2", {31'd0, UartOver}, 32'd0);
    check("big_wc", {16'd0, WordCount}, 32'd0);

    // N == MAX_WORDS is accepted: one word is written and the load is still open.
    do_reset();
    hdr = 32'(MaxW);
    for (int i = 0; i < 4; i++) send(hdr[8*i +: 8]);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    idle(3);
    check("max_err", {31'd0, LoadError}, 32'd0);
    check("max_over", {31'd0, UartOver}, 32'd0);
    check("max_writes", 32'(cap_addr.size()), 32'd1);
    if (cap_data.size() > 0) check("max_data", cap_data[0], 32'h1234_5678);

    // Reset in the middle of word 0 discards the partial bytes.
    do_reset();
    send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    send(8'hA5); send(8'h5A);
    idle(1);
    do_reset();
    words = '{32'hCAFE_F00D};
    load(1'b1, 1'b0);

`ifdef UART_LOADER_CHECKSUM_EN
    do_reset();
    words = '{32'hDDCC_BBAA};
    load(1'b0, 1'b0);
    do_reset();
    load(1'b0, 1'b1);
`endif

    // Randomized frames with random gaps.
    for (int t = 0; t < 8; t++) begin
      do_reset();
      words.delete();
      repeat ($urandom_range(0, 5)) words.push_back($urandom);
      load(1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
